fp_normalize_pack: RTL and testbench

FP_NORMALIZE_PACK -- requirements
Module: fp_normalize_pack

---
 rtl/fp_normalize_pack.sv | 199 +++++++++++++++++++
 tb/tb_fp_normalize_pack.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_normalize_pack.sv
// fp_normalize_pack: normalizes a raw adder magnitude, rounds it and packs it as
// an IEEE-754 single. One result is in flight at a time (valid/ready on both sides).
// Optional feature macro: FPN_ROUND_NEAREST_EN selects round-to-nearest-even.
// When the macro is undefined, results are truncated.
module fp_normalize_pack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [24:0] in_mant,
  input  logic [2:0]  in_grs,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow
);

  localparam int unsigned EXP_W     = 9;   // one spare bit so exp+1 past 255 is visible
  localparam int unsigned MANT_W    = 25;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned MAX_SHIFT = 23;
  localparam int unsigned ST_W      = 3;

  localparam logic [ST_W-1:0] IDLE  = 3'd0;
  localparam logic [ST_W-1:0] NORM  = 3'd1;
  localparam logic [ST_W-1:0] SHIFT = 3'd2;
  localparam logic [ST_W-1:0] ROUND = 3'd3;
  localparam logic [ST_W-1:0] DONE  = 3'd4;

  logic [ST_W-1:0]   state_q, state_d;
  logic              sign_q, sign_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic              g_q, g_d;
  logic              r_q, r_d;
  logic              s_q, s_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       result_q, result_d;
  logic              overflow_q, overflow_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;

  logic [MANT_W-1:0] rnd_mant;
  logic [EXP_W-1:0]  rnd_exp;
  logic              inc;

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      g_q         <= 1'b0;
      r_q         <= 1'b0;
      s_q         <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      g_q         <= g_d;
      r_q         <= r_d;
      s_q         <= s_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Next-state, datapath step and packing for each FSM state
  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    mant_d     = mant_q;
    g_d        = g_q;
    r_d        = r_q;
    s_d        = s_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    rnd_mant   = '0;
    rnd_exp    = '0;
    inc        = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          sign_d  = in_sign;
          exp_d   = {1'b0, in_exp};
          mant_d  = in_mant;
          g_d     = in_grs[2];
          r_d     = in_grs[1];
          s_d     = in_grs[0];
          cnt_d   = '0;
          state_d = NORM;
        end
      end

      NORM: begin
        if (exp_q == 9'd255) begin
          // Inf/NaN operand passes straight through
          result_d   = {sign_q, 8'hFF, mant_q[22:0]};
          overflow_d = 1'b0;
          state_d    = DONE;
        end else if (mant_q == '0 && {g_q, r_q, s_q} == 3'b000) begin
          // Exact cancellation always yields +0
          result_d   = 32'h0000_0000;
          overflow_d = 1'b0;
          state_d    = DONE;
        end else if (mant_q[24]) begin
          // Carry out: one right shift, the dropped bit becomes the new guard
          mant_d  = {1'b0, mant_q[24:1]};
          g_d     = mant_q[0];
          r_d     = g_q;
          s_d     = r_q | s_q;
          exp_d   = exp_q + 9'd1;
          state_d = ROUND;
        end else if (mant_q[23]) begin
          state_d = ROUND;
        end else if (exp_q > 9'd1) begin
          state_d = SHIFT;
        end else begin
          exp_d   = '0;
          state_d = ROUND;
        end
      end

      SHIFT: begin
        // One left shift per cycle; guard feeds the LSB, sticky is kept
        mant_d = {mant_q[23:0], g_q};
        g_d    = r_q;
        r_d    = 1'b0;
        exp_d  = exp_q - 9'd1;
        cnt_d  = cnt_q + 5'd1;
        if (mant_q[22] || exp_q == 9'd2 || cnt_q == CNT_W'(MAX_SHIFT - 1)) begin
          state_d = ROUND;
          if (!mant_q[22]) begin
            exp_d = '0;
          end
        end
      end

      ROUND: begin
`ifdef FPN_ROUND_NEAREST_EN
        inc = g_q & (r_q | s_q | mant_q[0]);
`else
        inc = 1'b0;
`endif
        rnd_mant = {1'b0, mant_q[23:0]} + MANT_W'(inc);
        rnd_exp  = exp_q;
        if (rnd_mant[24]) begin
          rnd_mant = {1'b0, rnd_mant[24:1]};
          rnd_exp  = exp_q + 9'd1;
        end else if (exp_q == '0 && rnd_mant[23]) begin
          // A denormal that rounds up into the hidden bit becomes the smallest normal
          rnd_exp = 9'd1;
        end
        if (rnd_exp >= 9'd255) begin
          result_d   = {sign_q, 8'hFF, 23'h0};
          overflow_d = 1'b1;
        end else begin
          result_d   = {sign_q, rnd_exp[7:0], rnd_mant[22:0]};
          overflow_d = 1'b0;
        end
        state_d = DONE;
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fp_normalize_pack.sv
// Self-checking bench for fp_normalize_pack: directed vector table, randomized
// vectors against an arithmetic reference model, plus backpressure and reset sequences.
// Honours FPN_ROUND_NEAREST_EN the same way the design does.
module tb_fp_normalize_pack;

`ifdef FPN_ROUND_NEAREST_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic [2:0]  in_grs;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [24:0] mant;
    logic [2:0]  grs;
    logic [31:0] res;
    logic        ovf;
    int          lat;   // 0: latency not checked
  } vec_t;

  fp_normalize_pack dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .in_grs    (in_grs),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference: value-level normalization via leading-zero count, then rounding
  function automatic void model(input logic s, input logic [7:0] e_in, input logic [24:0] m_in,
                                input logic [2:0] grs, output logic [31:0] res,
                                output logic ovf, output int lat);
    int          e, k, lz;
    logic [25:0] v;
    logic [23:0] m24;
    logic        g, r, st;
    longint      mm;
    ovf = 1'b0;
    lat = 0;
    res = '0;
    if (e_in == 8'd255) begin
      res = {s, 8'hFF, m_in[22:0]};
      return;
    end
    if (m_in == '0 && grs == 3'b000) begin
      res = 32'h0;
      return;
    end
    e = int'(e_in);
    k = 0;
    if (m_in[24]) begin
      m24 = m_in[24:1];
      g   = m_in[0];
      r   = grs[2];
      st  = grs[1] | grs[0];
      e   = e + 1;
    end else begin
      v  = {m_in[23:0], grs[2], grs[1]};
      st = grs[0];
      lz = 0;
      for (int i = 25; i >= 0 && !v[i]; i--) lz++;
      if (!m_in[23] && e > 1) begin
        k = lz;
        if (k > e - 1) k = e - 1;
        if (k > 23) k = 23;
      end
      v   = v << k;
      m24 = v[25:2];
      g   = v[1];
      r   = v[0];
      e   = e - k;
      if (!m24[23]) e = 0;
    end
    lat = 3 + k;
    mm = longint'(m24);
    if (RNE && g && (r || st || m24[0])) mm = mm + 1;
    if (mm >= (64'd1 << 24)) begin
      mm = mm / 2;
      e  = e + 1;
    end else if (e == 0 && mm >= (64'd1 << 23)) begin
      e = 1;
    end
    if (e >= 255) begin
      res = {s, 8'hFF, 23'h0};
      ovf = 1'b1;
    end else begin
      res = {s, 8'(e), 23'(mm)};
    end
  endfunction

  // Offer one vector, wait (bounded) for the result, check it and its acceptance
  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    in_sign  = v.sign;
    in_exp   = v.exp;
    in_mant  = v.mant;
    in_grs   = v.grs;
    in_valid = 1'b1;
    chk({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL %s timeout: out_valid still 0 after %0d cycles, expected 1", tag, lat);
    end else begin
      chk({tag, " result"}, result, v.res);
      chk({tag, " overflow"}, 32'(overflow), 32'(v.ovf));
      if (v.lat != 0) chk({tag, " latency"}, 32'(lat), 32'(v.lat));
      @(posedge clk); #1;
      chk({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
      chk({tag, " in_ready back"}, 32'(in_ready), 32'd1);
    end
  endtask

  vec_t tbl[13];
  vec_t rv;
  int   sel, sh, lat_w, seen;

  initial begin
    // 6.9 + 4.2: 6.9 carries biased exponent 129, the sum carries out to 11.1
    tbl[0]  = '{1'b0, 8'd129, 25'b10_11000110011001100110011, 3'b000,
                RNE ? 32'h4131999A : 32'h41319999, 1'b0, 3};
    tbl[1]  = '{1'b0, 8'd129, 25'b00_10101100110011001100111, 3'b000, 32'h402CCCCE, 1'b0, 4};
    tbl[2]  = '{1'b1, 8'd130, 25'h0000000, 3'b000, 32'h00000000, 1'b0, 0};
    tbl[3]  = '{1'b0, 8'd254, 25'h1000000, 3'b000, 32'h7F800000, 1'b1, 3};
    tbl[4]  = '{1'b0, 8'd255, 25'h0400001, 3'b000, 32'h7FC00001, 1'b0, 0};
    tbl[5]  = '{1'b0, 8'd127, 25'h0800000, 3'b000, 32'h3F800000, 1'b0, 3};
    tbl[6]  = '{1'b0, 8'd1,   25'h0000010, 3'b000, 32'h00000010, 1'b0, 3};
    tbl[7]  = '{1'b0, 8'd127, 25'h0000008, 3'b000, 32'h35800000, 1'b0, 23};
    tbl[8]  = '{1'b0, 8'd3,   25'h0000100, 3'b000, 32'h00000400, 1'b0, 5};
    tbl[9]  = '{1'b1, 8'd100, 25'h1FFFFFF, 3'b000,
                RNE ? 32'hB3000000 : 32'hB2FFFFFF, 1'b0, 3};
    tbl[10] = '{1'b0, 8'd127, 25'h0800000, 3'b100, 32'h3F800000, 1'b0, 3};
    tbl[11] = '{1'b0, 8'd127, 25'h0800000, 3'b101,
                RNE ? 32'h3F800001 : 32'h3F800000, 1'b0, 3};
    tbl[12] = '{1'b0, 8'd254, 25'h0FFFFFF, 3'b110,
                RNE ? 32'h7F800000 : 32'h7F7FFFFF, RNE, 3};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    in_grs    = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset result", result, 32'h0);
    chk("reset overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    chk("reset in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 13; i++) run_vec(tbl[i], $sformatf("tbl[%0d]", i));

    // Backpressure: result and flags hold while the consumer stalls
    out_ready = 1'b0;
    in_sign = 1'b0; in_exp = 8'd129; in_mant = 25'b00_10101100110011001100111; in_grs = 3'b000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat_w = 1;
    while (!out_valid && lat_w < 60) begin
      @(posedge clk); #1;
      lat_w++;
    end
    chk("stall out_valid rise", 32'(out_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("stall[%0d] result", c), result, 32'h402CCCCE);
      chk($sformatf("stall[%0d] out_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("stall[%0d] in_ready", c), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall release out_valid", 32'(out_valid), 32'd0);
    chk("stall release in_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of a long SHIFT run discards the result
    in_sign = 1'b0; in_exp = 8'd127; in_mant = 25'h0000008; in_grs = 3'b000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("midreset out_valid", 32'(out_valid), 32'd0);
    chk("midreset result", result, 32'h0);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("midreset no output", 32'(seen), 32'd0);
    chk("midreset in_ready", 32'(in_ready), 32'd1);
    run_vec(tbl[5], "after reset");

    // Randomized vectors against the reference model
    for (int i = 0; i < 300; i++) begin
      sel     = $urandom_range(0, 19);
      rv.sign = 1'($urandom_range(0, 1));
      rv.exp  = 8'($urandom_range(1, 254));
      rv.grs  = 3'($urandom);
      sh      = $urandom_range(0, 24);
      rv.mant = 25'($urandom) >> sh;
      if (rv.mant[23:0] == '0) rv.mant[0] = 1'b1;
      if (sel == 0) rv.exp = 8'd255;
      if (sel == 1) begin
        rv.mant = '0;
        rv.grs  = 3'b000;
      end
      if (sel == 2) rv.exp = 8'($urandom_range(0, 4));
      if (sel == 3) rv.exp = 8'd254;
      model(rv.sign, rv.exp, rv.mant, rv.grs, rv.res, rv.ovf, rv.lat);
      if (sel <= 1) rv.lat = 0;
      run_vec(rv, $sformatf("rand[%0d]", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
